factorial_engine: RTL

- Sequential compute core behind the memory-mapped factorial accelerator.
- Accepts a one-cycle go pulse and a 4-bit operand n, then computes n! by repeated multiply-accumulate.
- Presents a 32-bit result with a one-cycle done pulse and an overflow error flag.
- Downstream consumers: the accelerator's result register and its done/err status flip-flops.

---
 rtl/fact_pkg.sv | 26 ++
 rtl/factorial_engine_shift_mul.sv | 61 ++++++
 rtl/factorial_engine.sv | 129 ++++++++++++
 3 files changed

// File: rtl/fact_pkg.sv
// Shared definitions for the factorial engine.
//   FACT_DATA_W / FACT_N_W / FACT_MAX_N : default result width, operand width and
//                                         largest operand whose factorial fits.
//   state_t                             : control FSM encoding (also exported on debugcs).
//   FACT_TABLE                          : 0!..12! reference values.
package fact_pkg;

   localparam int FACT_DATA_W = 32;
   localparam int FACT_N_W    = 4;
   localparam int FACT_MAX_N  = 12;

   typedef enum logic [3:0] {
      S_IDLE  = 4'd0,
      S_MUL   = 4'd1,
      S_DONE  = 4'd2,
      S_MSTEP = 4'd3
   } state_t;

   localparam logic [31:0] FACT_TABLE [0:12] = '{
      32'd1,        32'd1,         32'd2,        32'd6,
      32'd24,       32'd120,       32'd720,      32'd5040,
      32'd40320,    32'd362880,    32'd3628800,  32'd39916800,
      32'd479001600
   };

endpackage

// File: rtl/factorial_engine_shift_mul.sv
// fact_shift_mul: iterative shift-add multiplier, one multiplier bit per cycle.
// Only built when FACT_ITER_MUL_EN is defined; in the default build this file is empty.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   start        : one-cycle pulse; captures mcand/mplier and consumes multiplier bit 0
//   mcand        : DATA_W-bit multiplicand (the accumulator)
//   mplier       : N_W-bit multiplier (the down-counter), examined LSB-first
//   ack          : high in the cycle the last multiplier bit is consumed
//   product      : low DATA_W bits of mcand*mplier, valid while ack=1
`ifdef FACT_ITER_MUL_EN
module fact_shift_mul #(
   parameter int DATA_W = 32,
   parameter int N_W    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [DATA_W-1:0] mcand,
   input  logic [N_W-1:0]    mplier,
   output logic              ack,
   output logic [DATA_W-1:0] product
);

   localparam int CW = $clog2(N_W + 1);

   logic [DATA_W-1:0] partial;
   logic [DATA_W-1:0] mcand_sh;
   logic [N_W-1:0]    mpl_rem;
   logic [CW-1:0]     bits_left;
   logic              active;
   logic [DATA_W-1:0] partial_nxt;

   // Bit 0 is folded in on the start edge so a full step takes exactly N_W edges.
   assign partial_nxt = partial + (mpl_rem[0] ? mcand_sh : '0);
   assign ack         = active && (bits_left == CW'(1));
   assign product     = partial_nxt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         partial   <= '0;
         mcand_sh  <= '0;
         mpl_rem   <= '0;
         bits_left <= '0;
         active    <= 1'b0;
      end else if (start) begin
         partial   <= mplier[0] ? mcand : '0;
         mcand_sh  <= mcand << 1;
         mpl_rem   <= mplier >> 1;
         bits_left <= CW'(N_W - 1);
         active    <= 1'b1;
      end else if (active) begin
         partial   <= partial_nxt;
         mcand_sh  <= mcand_sh << 1;
         mpl_rem   <= mpl_rem >> 1;
         bits_left <= bits_left - CW'(1);
         if (bits_left == CW'(1)) active <= 1'b0;
      end
   end

endmodule
`endif

// File: rtl/factorial_engine.sv
// factorial_engine: sequential n! core behind the memory-mapped factorial accelerator.
// Optional build macro FACT_ITER_MUL_EN: replaces the single-cycle multiply with the
// fact_shift_mul shift-add unit (state MSTEP, N_W cycles per multiply step).
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   go         : start pulse, accepted in IDLE or DONE
//   n          : operand, sampled on the accepting edge
//   done       : one-cycle completion pulse
//   result     : n! mod 2^DATA_W, stable from done until the next accepted go
//   err        : n > MAX_N, set on acceptance and held until the next accepted go
//   busy       : computation in progress
//   debugcs    : current state encoding
//
// state | meaning
// IDLE  | waiting for go
// MUL   | one multiply step per cycle (or launch of an iterative step)
// DONE  | done pulse; go here is accepted like in IDLE
// MSTEP | iterative multiply in flight (FACT_ITER_MUL_EN only)
module factorial_engine
   import fact_pkg::*;
#(
   parameter int DATA_W = FACT_DATA_W,
   parameter int N_W    = FACT_N_W,
   parameter int MAX_N  = FACT_MAX_N
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              go,
   input  logic [N_W-1:0]    n,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              err,
   output logic              busy,
   output logic [3:0]        debugcs
);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] acc, acc_nxt;
   logic [N_W-1:0]    cnt, cnt_nxt;
   logic              err_q, err_nxt;

`ifdef FACT_ITER_MUL_EN
   logic              mul_start;
   logic              mul_ack;
   logic [DATA_W-1:0] mul_product;

   fact_shift_mul #(
      .DATA_W (DATA_W),
      .N_W    (N_W)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .mcand   (acc),
      .mplier  (cnt),
      .ack     (mul_ack),
      .product (mul_product)
   );
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_IDLE;
         acc   <= '0;
         cnt   <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nxt;
         acc   <= acc_nxt;
         cnt   <= cnt_nxt;
         err_q <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      acc_nxt   = acc;
      cnt_nxt   = cnt;
      err_nxt   = err_q;
`ifdef FACT_ITER_MUL_EN
      mul_start = 1'b0;
`endif
      case (state)
         S_IDLE, S_DONE: begin
            if (go) begin
               acc_nxt   = DATA_W'(1);
               cnt_nxt   = n;
               err_nxt   = (int'(n) > MAX_N);
               state_nxt = S_MUL;
            end else begin
               state_nxt = S_IDLE;
            end
         end
         S_MUL: begin
            // cnt of 0 or 1 contributes nothing further to the product.
            if (cnt <= N_W'(1)) begin
               state_nxt = S_DONE;
            end else begin
`ifdef FACT_ITER_MUL_EN
               mul_start = 1'b1;
               state_nxt = S_MSTEP;
`else
               acc_nxt   = acc * DATA_W'(cnt);
               cnt_nxt   = cnt - N_W'(1);
`endif
            end
         end
         S_MSTEP: begin
`ifdef FACT_ITER_MUL_EN
            if (mul_ack) begin
               acc_nxt   = mul_product;
               cnt_nxt   = cnt - N_W'(1);
               state_nxt = S_MUL;
            end
`else
            state_nxt = S_IDLE;
`endif
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   assign done    = (state == S_DONE);
   assign busy    = (state == S_MUL) || (state == S_MSTEP);
   assign result  = acc;
   assign err     = err_q;
   assign debugcs = state;

endmodule
